fp_issue_ctrl: RTL and testbench
================================

Name: fp_issue_ctrl

Overview:
- Issue and writeback sequencer for the multi-cycle FPU, instantiated beside the ID stage control.
- Holds a one-entry scoreboard for the single outstanding FPU op and raises the ID stall on structural, RAW and WAW hazards.
- Drives the FPU valid/ack handshake.
- Arbitrates the FPU result onto the FP or integer register-file write port; FP loads and integer WB writes take priority.

Parameters:
TIMEOUT, 64, cycles in BUSY/DRAIN before fpu_timeout asserts
CNT_W, 16, width of busy_cycles perf counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID holds a real instruction
id_flush  in  1  squash ID instruction this cycle
id_fpu_op  in  1  ID instruction is a multi-cycle FPU op
id_rs1_fp, id_rs2_fp, id_rs3_fp  in  1 each  source n reads FP file (0 = integer file)
id_rs1_en, id_rs2_en, id_rs3_en  in  1 each  source n is used
id_rs1, id_rs2, id_rs3  in  5 each  source addresses
id_rd_en  in  1  ID instruction writes a destination
id_rd_fp  in  1  destination is the FP file
id_rd  in  5  destination address
kill  in  1  squash the in-flight FPU op (EX/WB flush)
fpu_busy  in  1  FPU cannot accept
fpu_done  in  1  FPU result valid; held until fpu_ack
fpu_valid  out  1  issue strobe to FPU
fpu_ack  out  1  result consumed
wb_fp_load  in  1  FP load writes FP file this cycle (priority)
wb_int_regwen  in  1  integer WB writes integer file this cycle (priority)
fpu_wb_en  out  1  write FPU result this cycle
fpu_wb_fp  out  1  1 = FP file, 0 = integer file
fpu_wb_addr  out  5  write address
stall  out  1  stall ID
pend_valid  out  1  scoreboard entry live
pend_rd  out  5  pending destination
busy_cycles  out  CNT_W  saturating count of non-IDLE cycles
fpu_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async): state IDLE; pend_valid=0, pend_rd=0, pend_fp=0, busy_cycles=0, fpu_timeout=0, wdog=0. All combinational outputs evaluate to 0 in IDLE with no ID input.
- States: IDLE, BUSY, WB, DRAIN.
- live = id_valid && !id_flush.
- Source match: src n matches when src_en && (src_fp == pend_fp) && (src == pend_rd) && pend_valid.
- Destination match: id_rd_en && (id_rd_fp == pend_fp) && (id_rd == pend_rd) && pend_valid.
- An integer x0 pending destination never matches.
- stall = live && (any source match || destination match || (id_fpu_op && (state != IDLE || fpu_busy))). Combinational, no latency.
- Issue: fpu_valid = live && id_fpu_op && state==IDLE && !fpu_busy && !stall.
  - On the issue edge: state becomes BUSY; pend_rd/pend_fp capture id_rd/id_rd_fp.
  - pend_valid = id_rd_en && !(integer x0 destination).
- BUSY:
  - kill → DRAIN; pend_valid cleared that edge. kill takes precedence over fpu_done.
  - else fpu_done → WB.
- WB:
  - port_free = pend_fp ? !wb_fp_load : !wb_int_regwen.
  - kill → fpu_ack=1, no write, → IDLE.
  - else if !pend_valid: fpu_ack=1, no write, → IDLE.
  - else if port_free: fpu_wb_en=1, fpu_wb_fp=pend_fp, fpu_wb_addr=pend_rd, fpu_ack=1, → IDLE; pend_valid cleared.
  - else hold in WB, no ack.
- DRAIN: fpu_ack = fpu_done; → IDLE on fpu_done. No register write.
- The same-cycle WB-exit and new issue is legal. Exit happens on the edge; the issue is only seen next cycle because the issue check requires state==IDLE. Minimum spacing between issues is 1 idle cycle.
- busy_cycles: +1 each cycle state != IDLE; saturates at all-ones.
- Watchdog:
  - wdog increments in BUSY and DRAIN and clears otherwise.
  - When wdog reaches TIMEOUT, fpu_timeout is set and stays set until rst.
  - The state machine is unaffected by the watchdog.
- Reset mid-operation returns to IDLE immediately. The FPU is expected to be reset by the same rst.

Test Plan:
- Issue fadd f3 (fpu_busy=0), fpu_done 4 cycles later, no port conflict → fpu_valid 1 cycle; state BUSY; WB writes f3 (fpu_wb_fp=1, addr 3) with fpu_ack; busy_cycles=5.
- With f3 pending, ID presents fmul reading f3 → stall=1 until the fpu_wb_en cycle, then 0. A read of integer x3 during the same window → stall=0.
- fcvt.w.s to x5; wb_int_regwen=1 for 2 cycles when the result arrives → WB held 2 cycles, write to integer x5 on the 3rd, ack simultaneous.
- Pending rd=x0 (integer) → no stall on x0 readers; WB acks without fpu_wb_en.
- kill in BUSY, then fpu_done → DRAIN; fpu_ack with fpu_done; no write; pend_valid=0 right after kill. kill and fpu_done in the same cycle → DRAIN.
- fpu_done never asserts, TIMEOUT=64 → fpu_timeout rises after 64 BUSY cycles and stays after a late fpu_done. Async rst mid-BUSY clears all state before the next clk edge.

Source files
------------

// File: rtl/fp_issue_ctrl.sv
// fp_issue_ctrl
//   Issue and writeback sequencer for the multi-cycle FPU, sitting beside the
//   ID stage control. Tracks the single outstanding FPU op in a one-entry
//   scoreboard, stalls ID on structural / RAW / WAW hazards, drives the FPU
//   valid/ack handshake and steers the FPU result onto the FP or integer
//   register-file write port when that port is not taken by a higher-priority
//   writer (FP load or integer WB).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   id_*                ID stage instruction description (valid, flush, sources,
//                       destination, FPU-op flag)
//   kill                squash the in-flight FPU op
//   fpu_busy/fpu_done   FPU status; fpu_done held until fpu_ack
//   fpu_valid/fpu_ack   issue strobe / result-consumed strobe to the FPU
//   wb_fp_load          FP load owns the FP write port this cycle
//   wb_int_regwen       integer WB owns the integer write port this cycle
//   fpu_wb_en/fp/addr   FPU result write request
//   stall               ID stall (combinational)
//   pend_valid/pend_rd  scoreboard entry
//   busy_cycles         saturating count of non-IDLE cycles
//   fpu_timeout         sticky watchdog flag
module fp_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_flush,
  input  logic             id_fpu_op,
  input  logic             id_rs1_fp,
  input  logic             id_rs2_fp,
  input  logic             id_rs3_fp,
  input  logic             id_rs1_en,
  input  logic             id_rs2_en,
  input  logic             id_rs3_en,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rs3,
  input  logic             id_rd_en,
  input  logic             id_rd_fp,
  input  logic [4:0]       id_rd,
  input  logic             kill,
  input  logic             fpu_busy,
  input  logic             fpu_done,
  output logic             fpu_valid,
  output logic             fpu_ack,
  input  logic             wb_fp_load,
  input  logic             wb_int_regwen,
  output logic             fpu_wb_en,
  output logic             fpu_wb_fp,
  output logic [4:0]       fpu_wb_addr,
  output logic             stall,
  output logic             pend_valid,
  output logic [4:0]       pend_rd,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             fpu_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_WB    = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_rd_q, pend_rd_d;
  logic             pend_fp_q, pend_fp_d;
  logic [CNT_W-1:0] busy_cycles_q, busy_cycles_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             fpu_timeout_q, fpu_timeout_d;

  logic             live_s;
  logic             pend_hit_s;
  logic             src_hit_s;
  logic             dst_hit_s;
  logic             struct_hit_s;
  logic             stall_s;
  logic             issue_s;
  logic             port_free_s;
  logic             fpu_ack_s;
  logic             wb_en_s;
  logic             wb_fp_s;
  logic [4:0]       wb_addr_s;

  // Register reference against the scoreboard entry.
  function automatic logic reg_match(input logic       en,
                                     input logic       fp,
                                     input logic [4:0] addr,
                                     input logic       pfp,
                                     input logic [4:0] prd,
                                     input logic       live_entry);
    return en && (fp == pfp) && (addr == prd) && live_entry;
  endfunction

  // Hazard detection and issue decision.
  always_comb begin
    live_s       = id_valid && !id_flush;
    // An integer x0 entry is never a real dependency.
    pend_hit_s   = pend_valid_q && !(!pend_fp_q && (pend_rd_q == 5'd0));
    src_hit_s    = reg_match(id_rs1_en, id_rs1_fp, id_rs1, pend_fp_q, pend_rd_q, pend_hit_s) ||
                   reg_match(id_rs2_en, id_rs2_fp, id_rs2, pend_fp_q, pend_rd_q, pend_hit_s) ||
                   reg_match(id_rs3_en, id_rs3_fp, id_rs3, pend_fp_q, pend_rd_q, pend_hit_s);
    dst_hit_s    = reg_match(id_rd_en, id_rd_fp, id_rd, pend_fp_q, pend_rd_q, pend_hit_s);
    struct_hit_s = id_fpu_op && ((state_q != S_IDLE) || fpu_busy);
    stall_s      = live_s && (src_hit_s || dst_hit_s || struct_hit_s);
    issue_s      = live_s && id_fpu_op && (state_q == S_IDLE) && !fpu_busy && !stall_s;
  end

  // Next-state, scoreboard update and handshake/writeback outputs.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_rd_d    = pend_rd_q;
    pend_fp_d    = pend_fp_q;
    fpu_ack_s    = 1'b0;
    wb_en_s      = 1'b0;
    wb_fp_s      = 1'b0;
    wb_addr_s    = 5'd0;
    port_free_s  = pend_fp_q ? !wb_fp_load : !wb_int_regwen;

    case (state_q)
      S_IDLE: begin
        if (issue_s) begin
          state_d      = S_BUSY;
          pend_rd_d    = id_rd;
          pend_fp_d    = id_rd_fp;
          pend_valid_d = id_rd_en && !(!id_rd_fp && (id_rd == 5'd0));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // kill wins over a same-cycle fpu_done: the result is drained unwritten.
        if (kill) begin
          state_d      = S_DRAIN;
          pend_valid_d = 1'b0;
        end else if (fpu_done) begin
          state_d = S_WB;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_WB: begin
        if (kill) begin
          fpu_ack_s    = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else if (!pend_valid_q) begin
          fpu_ack_s = 1'b1;
          state_d   = S_IDLE;
        end else if (port_free_s) begin
          wb_en_s      = 1'b1;
          wb_fp_s      = pend_fp_q;
          wb_addr_s    = pend_rd_q;
          fpu_ack_s    = 1'b1;
          pend_valid_d = 1'b0;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_DRAIN: begin
        fpu_ack_s = fpu_done;
        if (fpu_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d      = S_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  // Perf counter and watchdog.
  always_comb begin
    if ((state_q != S_IDLE) && (busy_cycles_q != {CNT_W{1'b1}})) begin
      busy_cycles_d = busy_cycles_q + CNT_W'(1);
    end else begin
      busy_cycles_d = busy_cycles_q;
    end

    if ((state_q == S_BUSY) || (state_q == S_DRAIN)) begin
      if (wdog_q == WD_W'(TIMEOUT)) begin
        wdog_d = wdog_q;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end else begin
      wdog_d = {WD_W{1'b0}};
    end

    fpu_timeout_d = fpu_timeout_q || (wdog_d == WD_W'(TIMEOUT));
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_valid_q  <= 1'b0;
      pend_rd_q     <= 5'd0;
      pend_fp_q     <= 1'b0;
      busy_cycles_q <= {CNT_W{1'b0}};
      wdog_q        <= {WD_W{1'b0}};
      fpu_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_rd_q     <= pend_rd_d;
      pend_fp_q     <= pend_fp_d;
      busy_cycles_q <= busy_cycles_d;
      wdog_q        <= wdog_d;
      fpu_timeout_q <= fpu_timeout_d;
    end
  end

  assign fpu_valid   = issue_s;
  assign fpu_ack     = fpu_ack_s;
  assign fpu_wb_en   = wb_en_s;
  assign fpu_wb_fp   = wb_fp_s;
  assign fpu_wb_addr = wb_addr_s;
  assign stall       = stall_s;
  assign pend_valid  = pend_valid_q;
  assign pend_rd     = pend_rd_q;
  assign busy_cycles = busy_cycles_q;
  assign fpu_timeout = fpu_timeout_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// tb_fp_issue_ctrl
//   Directed bench for fp_issue_ctrl: issue/writeback of FP and integer
//   results, RAW/structural stalls, port-conflict hold, x0 destination, kill
//   and drain, watchdog and asynchronous reset mid-operation.
module tb_fp_issue_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_flush, id_fpu_op;
  logic             id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic             id_rs1_en, id_rs2_en, id_rs3_en;
  logic [4:0]       id_rs1, id_rs2, id_rs3;
  logic             id_rd_en, id_rd_fp;
  logic [4:0]       id_rd;
  logic             kill, fpu_busy, fpu_done;
  logic             fpu_valid, fpu_ack;
  logic             wb_fp_load, wb_int_regwen;
  logic             fpu_wb_en, fpu_wb_fp;
  logic [4:0]       fpu_wb_addr;
  logic             stall, pend_valid;
  logic [4:0]       pend_rd;
  logic [CNT_W-1:0] busy_cycles;
  logic             fpu_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  fp_issue_ctrl #(.TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush), .id_fpu_op(id_fpu_op),
    .id_rs1_fp(id_rs1_fp), .id_rs2_fp(id_rs2_fp), .id_rs3_fp(id_rs3_fp),
    .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rs3_en(id_rs3_en),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3),
    .id_rd_en(id_rd_en), .id_rd_fp(id_rd_fp), .id_rd(id_rd),
    .kill(kill), .fpu_busy(fpu_busy), .fpu_done(fpu_done),
    .fpu_valid(fpu_valid), .fpu_ack(fpu_ack),
    .wb_fp_load(wb_fp_load), .wb_int_regwen(wb_int_regwen),
    .fpu_wb_en(fpu_wb_en), .fpu_wb_fp(fpu_wb_fp), .fpu_wb_addr(fpu_wb_addr),
    .stall(stall), .pend_valid(pend_valid), .pend_rd(pend_rd),
    .busy_cycles(busy_cycles), .fpu_timeout(fpu_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clr_id();
    id_valid  = 1'b0; id_flush  = 1'b0; id_fpu_op = 1'b0;
    id_rs1_fp = 1'b0; id_rs2_fp = 1'b0; id_rs3_fp = 1'b0;
    id_rs1_en = 1'b0; id_rs2_en = 1'b0; id_rs3_en = 1'b0;
    id_rs1    = 5'd0; id_rs2    = 5'd0; id_rs3    = 5'd0;
    id_rd_en  = 1'b0; id_rd_fp  = 1'b0; id_rd     = 5'd0;
  endtask

  // FPU op with one FP source and a destination.
  task automatic fpu_op(input logic [4:0] rs1, input logic rd_fp, input logic [4:0] rd);
    clr_id();
    id_valid = 1'b1; id_fpu_op = 1'b1;
    id_rs1_en = 1'b1; id_rs1_fp = 1'b1; id_rs1 = rs1;
    id_rd_en = 1'b1; id_rd_fp = rd_fp; id_rd = rd;
  endtask

  initial begin
    rst = 1'b1;
    clr_id();
    kill = 1'b0; fpu_busy = 1'b0; fpu_done = 1'b0;
    wb_fp_load = 1'b0; wb_int_regwen = 1'b0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_fpu_valid",   32'(fpu_valid),   32'd0);
    chk("rst_stall",       32'(stall),       32'd0);
    chk("rst_fpu_ack",     32'(fpu_ack),     32'd0);
    chk("rst_wb_en",       32'(fpu_wb_en),   32'd0);
    chk("rst_pend_valid",  32'(pend_valid),  32'd0);
    chk("rst_pend_rd",     32'(pend_rd),     32'd0);
    chk("rst_busy_cycles", 32'(busy_cycles), 32'd0);
    chk("rst_timeout",     32'(fpu_timeout), 32'd0);
    rst = 1'b0;
    cyc();

    // fadd f3 <- f1, f2
    fpu_op(5'd1, 1'b1, 5'd3);
    id_rs2_en = 1'b1; id_rs2_fp = 1'b1; id_rs2 = 5'd2;
    mid();
    chk("t1_issue_valid", 32'(fpu_valid), 32'd1);
    chk("t1_issue_stall", 32'(stall),     32'd0);
    cyc();
    clr_id();
    chk("t1_pend_valid", 32'(pend_valid), 32'd1);
    chk("t1_pend_rd",    32'(pend_rd),    32'd3);
    // BUSY 1: fmul f4 <- f3
    fpu_op(5'd3, 1'b1, 5'd4);
    mid();
    chk("t1_raw_stall",   32'(stall),     32'd1);
    chk("t1_raw_novalid", 32'(fpu_valid), 32'd0);
    cyc();
    // BUSY 2: integer op reading x3
    clr_id();
    id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1_fp = 1'b0; id_rs1 = 5'd3;
    id_rd_en = 1'b1; id_rd_fp = 1'b0; id_rd = 5'd7;
    mid();
    chk("t1_int_x3_nostall", 32'(stall), 32'd0);
    cyc();
    // BUSY 3
    fpu_op(5'd3, 1'b1, 5'd4);
    mid();
    chk("t1_raw_stall2", 32'(stall), 32'd1);
    cyc();
    // BUSY 4: result arrives
    fpu_done = 1'b1;
    mid();
    chk("t1_busy_noack", 32'(fpu_ack),   32'd0);
    chk("t1_busy_nowb",  32'(fpu_wb_en), 32'd0);
    chk("t1_done_stall", 32'(stall),     32'd1);
    cyc();
    // WB
    mid();
    chk("t1_wb_en",   32'(fpu_wb_en),   32'd1);
    chk("t1_wb_fp",   32'(fpu_wb_fp),   32'd1);
    chk("t1_wb_addr", 32'(fpu_wb_addr), 32'd3);
    chk("t1_wb_ack",  32'(fpu_ack),     32'd1);
    chk("t1_wb_stall", 32'(stall),      32'd1);
    cyc();
    fpu_done = 1'b0;
    // IDLE: fmul no longer stalls
    mid();
    chk("t1_after_stall", 32'(stall),       32'd0);
    chk("t1_after_valid", 32'(fpu_valid),   32'd1);
    chk("t1_after_pend",  32'(pend_valid),  32'd0);
    chk("t1_busy_cycles", 32'(busy_cycles), 32'd5);
    clr_id();
    cyc();

    // fcvt.w.s x5 <- f1 with integer port blocked 2 cycles
    fpu_op(5'd1, 1'b0, 5'd5);
    mid();
    chk("t2_issue_valid", 32'(fpu_valid), 32'd1);
    cyc();
    clr_id();
    fpu_done = 1'b1;
    cyc();
    wb_int_regwen = 1'b1;
    mid();
    chk("t2_hold1_wb",  32'(fpu_wb_en), 32'd0);
    chk("t2_hold1_ack", 32'(fpu_ack),   32'd0);
    cyc();
    mid();
    chk("t2_hold2_wb",  32'(fpu_wb_en), 32'd0);
    chk("t2_hold2_ack", 32'(fpu_ack),   32'd0);
    cyc();
    wb_int_regwen = 1'b0;
    wb_fp_load = 1'b1;
    mid();
    chk("t2_wb_en",   32'(fpu_wb_en),   32'd1);
    chk("t2_wb_fp",   32'(fpu_wb_fp),   32'd0);
    chk("t2_wb_addr", 32'(fpu_wb_addr), 32'd5);
    chk("t2_wb_ack",  32'(fpu_ack),     32'd1);
    cyc();
    fpu_done = 1'b0;
    wb_fp_load = 1'b0;
    chk("t2_busy_cycles", 32'(busy_cycles), 32'd9);
    chk("t2_pend_clear",  32'(pend_valid),  32'd0);

    // Structural stall on fpu_busy, then flush removes it
    fpu_op(5'd1, 1'b1, 5'd1);
    fpu_busy = 1'b1;
    mid();
    chk("t3_fpubusy_stall", 32'(stall),     32'd1);
    chk("t3_fpubusy_valid", 32'(fpu_valid), 32'd0);
    id_flush = 1'b1;
    #1;
    chk("t3_flush_stall", 32'(stall), 32'd0);
    clr_id();
    fpu_busy = 1'b0;
    cyc();

    // Pending integer x0
    fpu_op(5'd1, 1'b0, 5'd0);
    mid();
    chk("t3_x0_issue", 32'(fpu_valid), 32'd1);
    cyc();
    clr_id();
    chk("t3_x0_pend_valid", 32'(pend_valid), 32'd0);
    id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1_fp = 1'b0; id_rs1 = 5'd0;
    id_rd_en = 1'b1; id_rd_fp = 1'b0; id_rd = 5'd0;
    mid();
    chk("t3_x0_nostall", 32'(stall), 32'd0);
    cyc();
    clr_id();
    fpu_done = 1'b1;
    cyc();
    mid();
    chk("t3_x0_ack",  32'(fpu_ack),   32'd1);
    chk("t3_x0_nowb", 32'(fpu_wb_en), 32'd0);
    cyc();
    fpu_done = 1'b0;
    chk("t3_busy_cycles", 32'(busy_cycles), 32'd12);

    // kill in BUSY, result drained later
    fpu_op(5'd1, 1'b1, 5'd8);
    mid();
    chk("t4_issue", 32'(fpu_valid), 32'd1);
    cyc();
    fpu_op(5'd13, 1'b1, 5'd12);
    kill = 1'b1;
    mid();
    chk("t4_struct_stall", 32'(stall),   32'd1);
    chk("t4_kill_noack",   32'(fpu_ack), 32'd0);
    cyc();
    kill = 1'b0;
    clr_id();
    chk("t4_kill_pend", 32'(pend_valid), 32'd0);
    id_valid = 1'b1; id_rs1_en = 1'b1; id_rs1_fp = 1'b1; id_rs1 = 5'd8;
    mid();
    chk("t4_drain_nostall", 32'(stall),   32'd0);
    chk("t4_drain_noack",   32'(fpu_ack), 32'd0);
    cyc();
    clr_id();
    fpu_done = 1'b1;
    mid();
    chk("t4_drain_ack",  32'(fpu_ack),   32'd1);
    chk("t4_drain_nowb", 32'(fpu_wb_en), 32'd0);
    cyc();
    fpu_done = 1'b0;
    chk("t4_busy_cycles", 32'(busy_cycles), 32'd15);

    // kill and fpu_done together go to DRAIN
    fpu_op(5'd1, 1'b1, 5'd9);
    cyc();
    clr_id();
    kill = 1'b1;
    fpu_done = 1'b1;
    mid();
    chk("t4b_busy_noack", 32'(fpu_ack),   32'd0);
    chk("t4b_busy_nowb",  32'(fpu_wb_en), 32'd0);
    cyc();
    kill = 1'b0;
    mid();
    chk("t4b_drain_ack",  32'(fpu_ack),   32'd1);
    chk("t4b_drain_nowb", 32'(fpu_wb_en), 32'd0);
    cyc();
    fpu_done = 1'b0;
    chk("t4b_busy_cycles", 32'(busy_cycles), 32'd17);

    // Watchdog: 64 BUSY cycles without a result
    fpu_op(5'd1, 1'b1, 5'd10);
    cyc();
    clr_id();
    repeat (63) cyc();
    chk("t5_timeout_63", 32'(fpu_timeout), 32'd0);
    cyc();
    chk("t5_timeout_64", 32'(fpu_timeout), 32'd1);
    fpu_done = 1'b1;
    cyc();
    mid();
    chk("t5_late_wb_en",   32'(fpu_wb_en),   32'd1);
    chk("t5_late_wb_addr", 32'(fpu_wb_addr), 32'd10);
    cyc();
    fpu_done = 1'b0;
    cyc();
    chk("t5_timeout_sticky", 32'(fpu_timeout), 32'd1);

    // Asynchronous reset while BUSY
    fpu_op(5'd1, 1'b1, 5'd11);
    cyc();
    clr_id();
    cyc();
    chk("t6_pre_pend", 32'(pend_valid), 32'd1);
    rst = 1'b1;
    #2;
    chk("t6_rst_pend",    32'(pend_valid),  32'd0);
    chk("t6_rst_pend_rd", 32'(pend_rd),     32'd0);
    chk("t6_rst_busy",    32'(busy_cycles), 32'd0);
    chk("t6_rst_timeout", 32'(fpu_timeout), 32'd0);
    rst = 1'b0;
    cyc();
    fpu_op(5'd2, 1'b1, 5'd1);
    mid();
    chk("t6_idle_issue", 32'(fpu_valid), 32'd1);
    clr_id();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
